// File: rtl/vga_demo_sequencer.sv
// Frame-synchronous scheduler for the VGA demo: steps colour depth and demo mode on vsync
// boundaries, supports a manual override, and pulses the demo core's reset on mode changes.
module vga_demo_sequencer #(
  parameter int unsigned FRAMES_PER_DEPTH = 8,
  parameter int unsigned RST_CYCLES       = 4,
  parameter bit          VSYNC_ACT_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       pause,
  input  logic       manual_en,
  input  logic [2:0] manual_depth,
  input  logic [3:0] manual_mode,
  output logic [2:0] depth,
  output logic [3:0] mode,
  output logic [1:0] epoch,
  output logic       project_rst_n,
  output logic       frame_tick
);

  localparam logic       VSYNC_IDLE = VSYNC_ACT_LOW ? 1'b1 : 1'b0;
  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_DEPTH - 1);
  localparam logic [7:0] PULSE_LEN  = 8'(RST_CYCLES);

  typedef enum logic {RUN, PULSE} state_t;

  state_t     state;
  logic [7:0] pulse_cnt;
  logic [7:0] frame_cnt;
  logic [2:0] auto_depth;
  logic [2:0] idx;
  logic       manual_active;
  logic       vsync_q;
  logic       frame_edge;

  function automatic logic [3:0] mode_lut(input logic [2:0] i);
    case (i)
      3'd0:    mode_lut = 4'd1;
      3'd1:    mode_lut = 4'd4;
      3'd2:    mode_lut = 4'd3;
      3'd3:    mode_lut = 4'd5;
      3'd4:    mode_lut = 4'd2;
      3'd5:    mode_lut = 4'd4;
      3'd6:    mode_lut = 4'd7;
      default: mode_lut = 4'd6;
    endcase
  endfunction

  assign frame_edge = (vsync_q == VSYNC_IDLE) && (vsync != VSYNC_IDLE);

  // NOTE: every register here is state, so all updates use non-blocking assignments;
  // blocking ones would let later statements see this cycle's new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PULSE;
      pulse_cnt     <= PULSE_LEN;
      project_rst_n <= 1'b0;
      vsync_q       <= VSYNC_IDLE;
      frame_tick    <= 1'b0;
      frame_cnt     <= 8'd0;
      auto_depth    <= 3'd0;
      idx           <= 3'd0;
      epoch         <= 2'd0;
      manual_active <= 1'b0;
      depth         <= 3'd0;
      mode          <= 4'd1;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= frame_edge;

      if (state == PULSE) begin
        // Frame edges during the pulse only tick; nothing is counted or applied.
        if (pulse_cnt <= 8'd1) begin
          state         <= RUN;
          project_rst_n <= 1'b1;
        end else begin
          pulse_cnt <= pulse_cnt - 8'd1;
        end
      end else if (frame_edge) begin
        if (manual_en) begin
          manual_active <= 1'b1;
          depth         <= manual_depth;
          mode          <= manual_mode;
          if (manual_mode != mode) begin
            state         <= PULSE;
            pulse_cnt     <= PULSE_LEN;
            project_rst_n <= 1'b0;
          end
        end else if (manual_active) begin
          // Leaving manual: this edge only restores the frozen auto state.
          manual_active <= 1'b0;
          depth         <= auto_depth;
          mode          <= mode_lut(idx);
          if (mode_lut(idx) != mode) begin
            state         <= PULSE;
            pulse_cnt     <= PULSE_LEN;
            project_rst_n <= 1'b0;
          end
        end else if (!pause) begin
          if (frame_cnt < LAST_FRAME) begin
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            frame_cnt <= 8'd0;
            if (auto_depth == 3'd7) begin
              auto_depth    <= 3'd0;
              depth         <= 3'd0;
              idx           <= idx + 3'd1;
              mode          <= mode_lut(idx + 3'd1);
              if (idx == 3'd7) epoch <= epoch + 2'd1;
              state         <= PULSE;
              pulse_cnt     <= PULSE_LEN;
              project_rst_n <= 1'b0;
            end else begin
              auto_depth <= auto_depth + 3'd1;
              depth      <= auto_depth + 3'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_demo_sequencer.sv
// Directed bench for vga_demo_sequencer: reset pulse timing, auto stepping and epoch wrap,
// manual override and pause via a vector table, plus edge-during-pulse and reset-mid-pulse cases.
module tb_vga_demo_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b1;
  logic       pause = 1'b0;
  logic       manual_en = 1'b0;
  logic [2:0] manual_depth = 3'd0;
  logic [3:0] manual_mode = 4'd0;
  logic [2:0] depth;
  logic [3:0] mode;
  logic [1:0] epoch;
  logic       project_rst_n;
  logic       frame_tick;

  int n_cmp  = 0;
  int n_fail = 0;

  vga_demo_sequencer #(
    .FRAMES_PER_DEPTH(2),
    .RST_CYCLES      (4),
    .VSYNC_ACT_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .pause        (pause),
    .manual_en    (manual_en),
    .manual_depth (manual_depth),
    .manual_mode  (manual_mode),
    .depth        (depth),
    .mode         (mode),
    .epoch        (epoch),
    .project_rst_n(project_rst_n),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pause;
    logic       man_en;
    logic [2:0] man_depth;
    logic [3:0] man_mode;
    logic [2:0] exp_depth;
    logic [3:0] exp_mode;
    logic       exp_pulse;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One 1->0 vsync transition; samples just after the posedge that registers it.
  task automatic do_edge(output logic tick, output logic rstn);
    @(negedge clk) vsync = 1'b0;
    @(posedge clk);
    #1;
    tick = frame_tick;
    rstn = project_rst_n;
    @(negedge clk) vsync = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts posedges until project_rst_n goes high, starting while it is low.
  task automatic measure_pulse(output int n);
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (project_rst_n) break;
    end
  endtask

  task automatic run_edges(input int n);
    logic t, r;
    for (int i = 0; i < n; i++) begin
      do_edge(t, r);
      check("auto_tick", t, 1);
      idle(6);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t, r;
    int   n;
    logic [2:0] prev_depth;
    logic [3:0] prev_mode;

    vecs[0]  = '{1'b0, 1'b1, 3'd5, 4'd7, 3'd5, 4'd7, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 3'd2, 4'd7, 3'd2, 4'd7, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 3'd3, 4'd7, 3'd3, 4'd7, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd1, 4'd1, 1'b0};
    for (int i = 6; i <= 10; i++) vecs[i] = '{1'b1, 1'b0, 3'd4, 4'd9, 3'd1, 4'd1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd1, 4'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd2, 4'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'd6, 4'd1, 3'd6, 4'd1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd2, 4'd1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd2, 4'd1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd3, 4'd1, 1'b0};

    // Reset state and the initial reset pulse.
    repeat (2) @(posedge clk);
    #1;
    check("rst_depth", depth, 0);
    check("rst_mode", mode, 1);
    check("rst_epoch", epoch, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_rstn", project_rst_n, 0);
    @(negedge clk) rst = 1'b0;
    measure_pulse(n);
    check("init_pulse_len", n, 4);
    idle(3);

    // Auto stepping: two edges per depth step.
    do_edge(t, r);
    check("e1_tick", t, 1);
    check("e1_depth", depth, 0);
    @(posedge clk);
    #1;
    check("tick_one_cycle", frame_tick, 0);
    idle(5);
    do_edge(t, r);
    check("e2_tick", t, 1);
    check("e2_depth", depth, 1);
    idle(6);
    run_edges(13);
    check("e15_depth", depth, 7);
    check("e15_mode", mode, 1);
    do_edge(t, r);
    check("e16_depth", depth, 0);
    check("e16_mode", mode, 4);
    check("e16_rstn", r, 0);
    measure_pulse(n);
    check("e16_pulse_len", n, 4);
    idle(4);

    // Full table passes and epoch wrap.
    run_edges(112);
    check("e128_mode", mode, 1);
    check("e128_depth", depth, 0);
    check("e128_epoch", epoch, 1);
    run_edges(128);
    check("e256_epoch", epoch, 2);
    run_edges(128);
    check("e384_epoch", epoch, 3);
    run_edges(128);
    check("e512_epoch", epoch, 0);
    check("e512_mode", mode, 1);

    // Manual override and pause vectors.
    prev_depth = 3'd0;
    prev_mode  = 4'd1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      pause        = vecs[i].pause;
      manual_en    = vecs[i].man_en;
      manual_depth = vecs[i].man_depth;
      manual_mode  = vecs[i].man_mode;
      idle(3);
      check($sformatf("v%0d_mid_depth", i), depth, prev_depth);
      check($sformatf("v%0d_mid_mode", i), mode, prev_mode);
      do_edge(t, r);
      check($sformatf("v%0d_tick", i), t, 1);
      check($sformatf("v%0d_depth", i), depth, vecs[i].exp_depth);
      check($sformatf("v%0d_mode", i), mode, vecs[i].exp_mode);
      check($sformatf("v%0d_rstn", i), r, !vecs[i].exp_pulse);
      prev_depth = vecs[i].exp_depth;
      prev_mode  = vecs[i].exp_mode;
      idle(6);
    end
    pause     = 1'b0;
    manual_en = 1'b0;

    // Edges spaced 2 cycles apart during a wrap pulse are ignored.
    run_edges(9);
    check("pre_wrap_depth", depth, 7);
    do_edge(t, r);
    check("wrap_depth", depth, 0);
    check("wrap_mode", mode, 4);
    check("wrap_rstn", r, 0);
    do_edge(t, r);
    check("in_pulse_tick1", t, 1);
    check("in_pulse_rstn1", r, 0);
    do_edge(t, r);
    check("in_pulse_tick2", t, 1);
    check("pulse_end_rstn", r, 1);
    check("in_pulse_depth", depth, 0);
    idle(4);
    do_edge(t, r);
    check("post_pulse_f1_depth", depth, 0);
    idle(6);
    do_edge(t, r);
    check("post_pulse_f2_depth", depth, 1);
    idle(6);

    // Reset asserted mid-pulse restarts a full-length pulse.
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_depth", depth, 0);
    check("rst2_mode", mode, 1);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_pulse_rstn", project_rst_n, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    measure_pulse(n);
    check("restart_pulse_len", n, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
